avg_ram_reader: RTL and testbench
=================================

# avg_ram_reader

Read-side sequencer for the 240-entry post-FFT averaging RAM. On a start pulse it sweeps read addresses 0..239 into the RAM's read-address port and absorbs the RAM's one-cycle synchronous read latency. It then streams the samples in address order over a valid/ready interface to the downstream post-FFT stage and reports the signed block sum on completion. It sits between the averaging RAM and the channel-estimation/demapping logic.

## Interface
- RAM_WIDTH, 16, sample width (signed)
- ADDR_WIDTH, 8, RAM address width
- DEPTH, 240, entries per sweep; must be ≤ 2^ADDR_WIDTH
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request to begin a sweep; ignored while busy
- wre  in  1  RAM write enable, monitored only; while high the RAM port is owned by the writer
- mem_read_addr  out  ADDR_WIDTH  read address to RAM
- mem_rdata  in  RAM_WIDTH  signed RAM read data, valid the cycle after an address is presented with wre low
- out_data  out  RAM_WIDTH  signed sample
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_last  out  1  marks sample at address DEPTH-1
- busy  out  1  sweep in progress (start..done)
- done  out  1  one-cycle pulse after last handshake
- sum_out  out  RAM_WIDTH+ADDR_WIDTH  signed sum of all DEPTH samples of the last sweep, held until next start

## Operation
- FSM states:
  - IDLE: start → READ. Clears sum and address counter.
  - READ: issues reads. After address DEPTH-1 is issued → DRAIN.
  - DRAIN: waits for the FIFO to empty and no read to be in flight. The final handshake → IDLE and pulses done.
- Read issue (READ only): issue when wre=0 and FIFO occupancy + in-flight < 2.
  - An issued read drives the address for one cycle and sets the in-flight flag.
  - The next cycle's mem_rdata is pushed into a 2-entry FIFO.
  - The address counter increments after each issue.
- wre=1 in READ: no issue that cycle; the counter holds. No data is lost and ordering is unchanged.
- Output: out_data/out_valid are driven by the FIFO head. A pop occurs on out_valid & out_ready. Data is held stable while out_valid=1 and out_ready=0.
- out_last is asserted with the head entry whose address was DEPTH-1.
- sum_out accumulates sign-extended out_data on each handshake. Width RAM_WIDTH+ADDR_WIDTH cannot overflow for DEPTH ≤ 256.
- start during busy: ignored. start coincident with done: ignored; a new start is needed next cycle.
- Reset, asynchronous and at any time including mid-sweep:
  - State → IDLE; FIFO, in-flight flag and counter cleared.
  - Outputs: mem_read_addr=0, out_data=0, out_valid=0, out_last=0, busy=0, done=0, sum_out=0.
- mem_read_addr idles at 0 outside READ.

## Timing
- start in cycle 0 → busy from cycle 1, mem_read_addr=0 in cycle 1, mem_rdata[0] in cycle 2, out_valid with sample 0 in cycle 3.
- With out_ready=1 and wre=0 throughout: one sample per cycle, address k in cycle 1+k, out_last in cycle 242, done and the final sum_out in cycle 243, busy low from cycle 243.
- Backpressure: out_ready low for N cycles stalls issue within 2 cycles. There is no overflow and no bubble beyond N cycles in total.
- Each cycle of wre high during READ delays completion by exactly one cycle.

## Structure
- Shared package avg_pkg: DEPTH=240, RAM_WIDTH, ADDR_WIDTH, SUM_WIDTH, FSM state enum {IDLE, READ, DRAIN}.
- One sub-module: skid_fifo (2-entry, RAM_WIDTH+1 bits wide to carry last, push/pop/count). The FSM, counter and accumulator stay in the top level.

## Test plan
- RAM model preloaded with value = address-120, start, out_ready=1: 240 samples −120..119 in order, out_last on 119, done in cycle 243, sum_out = −120.
- out_ready toggling 1,0,0,1 pattern: every sample delivered exactly once in order, out_data stable during stalls, no FIFO overflow.
- wre pulsed high for 5 cycles mid-sweep: no reads issued during the pulse, sequence intact, done delayed by exactly 5 cycles.
- start re-pulsed at cycle 50 and again coincident with done: both ignored, single 240-sample sweep.
- rst asserted at cycle 100 then released, then start: all outputs 0 during reset, the new sweep begins at address 0 with sum from 0.
- All entries 0x7FFF (then 0x8000): sum_out = 7864080 (then −7864320), no overflow.

Source files
------------

// File: rtl/avg_pkg.sv
// Shared constants and types for the averaging-RAM read sequencer.
//   RAM_WIDTH  : signed sample width
//   ADDR_WIDTH : RAM address width
//   DEPTH      : entries per sweep (must not exceed 2**ADDR_WIDTH)
//   SUM_WIDTH  : block-sum width; wide enough that DEPTH <= 256 samples cannot overflow
package avg_pkg;

  localparam int unsigned RAM_WIDTH  = 16;
  localparam int unsigned ADDR_WIDTH = 8;
  localparam int unsigned DEPTH      = 240;
  localparam int unsigned SUM_WIDTH  = RAM_WIDTH + ADDR_WIDTH;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StDrain
  } state_e;

endpackage

// File: rtl/avg_ram_reader_if.sv
// RAM read port plus downstream valid/ready sample stream.
//   mem_read_addr : read address to RAM (master drives)
//   mem_rdata     : RAM read data, one cycle after the address (slave drives)
//   wre           : RAM write enable, monitored by the master only
//   out_data      : signed sample to downstream
//   out_valid     : out_data valid
//   out_ready     : downstream accepts
//   out_last      : sample at address DEPTH-1
import avg_pkg::*;

interface avg_ram_reader_if;

  logic [ADDR_WIDTH-1:0] mem_read_addr;
  logic [RAM_WIDTH-1:0]  mem_rdata;
  logic                  wre;
  logic [RAM_WIDTH-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  out_last;

  modport master (
    output mem_read_addr, out_data, out_valid, out_last,
    input  mem_rdata, wre, out_ready
  );

  modport slave (
    input  mem_read_addr, out_data, out_valid, out_last,
    output mem_rdata, wre, out_ready
  );

endinterface

// File: rtl/skid_fifo.sv
// Two-entry FIFO absorbing the RAM read latency between issue and the output stream.
//   clk_i/rst_ni : clock, asynchronous active-low reset
//   push_i       : write push_data_i (never asserted when full unless pop_i is also high)
//   pop_i        : discard the head (never asserted when empty)
//   head_o       : oldest entry
//   count_o      : occupancy 0..2
module skid_fifo #(
  parameter int unsigned Width = 17
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] push_data_i,
  input  logic             pop_i,
  output logic [Width-1:0] head_o,
  output logic [1:0]       count_o
);

  logic [Width-1:0] mem0_q, mem0_d, mem1_q, mem1_d;
  logic [1:0]       count_q, count_d;

  always_comb begin
    mem0_d  = mem0_q;
    mem1_d  = mem1_q;
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10: begin
        if (count_q == 2'd0) mem0_d = push_data_i;
        else                 mem1_d = push_data_i;
        count_d = count_q + 2'd1;
      end
      2'b01: begin
        mem0_d  = mem1_q;
        count_d = count_q - 2'd1;
      end
      2'b11: begin
        // Occupancy unchanged: the new entry lands behind whatever survives the pop.
        if (count_q == 2'd1) begin
          mem0_d = push_data_i;
        end else begin
          mem0_d = mem1_q;
          mem1_d = push_data_i;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem0_q  <= '0;
      mem1_q  <= '0;
      count_q <= '0;
    end else begin
      mem0_q  <= mem0_d;
      mem1_q  <= mem1_d;
      count_q <= count_d;
    end
  end

  assign head_o  = mem0_q;
  assign count_o = count_q;

endmodule

// File: rtl/avg_ram_reader.sv
// Read-side sequencer for the post-FFT averaging RAM. A start pulse sweeps addresses
// 0..DEPTH-1, streams the samples in order over valid/ready and accumulates their signed sum.
//   clk     : clock, rising edge
//   rst     : asynchronous active-low reset
//   start   : one-cycle sweep request, ignored while busy or while done is high
//   busy    : sweep in progress
//   done    : one-cycle pulse after the final handshake
//   sum_out : signed sum of the last sweep, held until the next start
//   bus     : RAM read port and output stream
module avg_ram_reader
  import avg_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  output logic                        busy,
  output logic                        done,
  output logic signed [SUM_WIDTH-1:0] sum_out,
  avg_ram_reader_if.master            bus
);

  state_e                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       addr_q, addr_d;
  logic                        inflight_q, inflight_last_q;
  logic signed [SUM_WIDTH-1:0] sum_q, sum_d;
  logic                        done_q, done_d;

  logic [1:0]           fifo_count, occ_after;
  logic [RAM_WIDTH:0]   fifo_head;
  logic                 pop, issue, at_last_addr;

  assign at_last_addr  = addr_q == ADDR_WIDTH'(DEPTH - 1);
  assign bus.out_valid = fifo_count != 2'd0;
  assign pop           = bus.out_valid & bus.out_ready;

  // The entry popped this cycle already counts as free, which sustains one read per cycle.
  assign occ_after = fifo_count - {1'b0, pop} + {1'b0, inflight_q};
  assign issue     = (state_q == StRead) && !bus.wre && (occ_after < 2'd2);

  assign bus.mem_read_addr = issue ? addr_q : '0;
  assign bus.out_data      = bus.out_valid ? fifo_head[RAM_WIDTH-1:0] : '0;
  assign bus.out_last      = bus.out_valid & fifo_head[RAM_WIDTH];

  assign busy    = state_q != StIdle;
  assign done    = done_q;
  assign sum_out = sum_q;

  skid_fifo #(
    .Width(RAM_WIDTH + 1)
  ) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (inflight_q),
    .push_data_i({inflight_last_q, bus.mem_rdata}),
    .pop_i      (pop),
    .head_o     (fifo_head),
    .count_o    (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    if (pop) begin
      sum_d = sum_q + $signed({{ADDR_WIDTH{bus.out_data[RAM_WIDTH-1]}}, bus.out_data});
    end
    unique case (state_q)
      StIdle: begin
        // A start landing on the done pulse belongs to the sweep just finished.
        if (start && !done_q) begin
          state_d = StRead;
          addr_d  = '0;
          sum_d   = '0;
        end
      end
      StRead: begin
        if (issue) begin
          addr_d = addr_q + 1'b1;
          if (at_last_addr) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && fifo_head[RAM_WIDTH]) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= StIdle;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      sum_q           <= '0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && at_last_addr;
      sum_q           <= sum_d;
      done_q          <= done_d;
    end
  end

endmodule

// File: tb/tb_avg_ram_reader.sv
// Directed-plus-random bench for avg_ram_reader. The reference is the RAM image itself:
// the expected stream is ram[0..DEPTH-1] in order and the expected sum is its plain total.
module tb_avg_ram_reader;
  import avg_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic busy, done;
  logic signed [SUM_WIDTH-1:0] sum_out;

  avg_ram_reader_if bus ();

  avg_ram_reader dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .busy   (busy),
    .done   (done),
    .sum_out(sum_out),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  logic [RAM_WIDTH-1:0] ram [256];

  // Synchronous-read RAM; garbage while the writer owns the port.
  always @(posedge clk) begin
    if (!bus.wre) bus.mem_rdata <= ram[bus.mem_read_addr];
    else          bus.mem_rdata <= 16'hDEAD;
  end

  int n_cmp = 0;
  int n_fail = 0;

  int cyc, done_cyc, done_cnt, first_hs, last_idx, last_cnt;
  int stable_bad, wre_bad, post_busy;
  logic busy_c1, busy_done;
  logic [ADDR_WIDTH-1:0] addr_c1, addr_c5;
  logic signed [SUM_WIDTH-1:0] sum_done;
  logic [RAM_WIDTH-1:0] got [$];
  logic prev_valid, prev_ready, prev_last;
  logic [RAM_WIDTH-1:0] prev_data;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint exp_sum();
    longint s = 0;
    for (int i = 0; i < int'(DEPTH); i++) s += longint'($signed(ram[i]));
    return s;
  endfunction

  function automatic int order_errs();
    int e = 0;
    for (int i = 0; i < got.size() && i < int'(DEPTH); i++) if (got[i] !== ram[i]) e++;
    return e;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_addr"}, bus.mem_read_addr, 0);
    check({tag, "_data"}, bus.out_data, 0);
    check({tag, "_valid"}, bus.out_valid, 0);
    check({tag, "_last"}, bus.out_last, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sum"}, sum_out, 0);
  endtask

  // mode 0: ready high, 1: ready pattern 1,0,0,1, 2: random ready.
  task automatic sweep(input int mode, input int wre_at, input int wre_len,
                       input bit restart, input int abort_at);
    got.delete();
    done_cyc = -1; done_cnt = 0; first_hs = -1; last_idx = -1; last_cnt = 0;
    stable_bad = 0; wre_bad = 0; post_busy = 0; prev_valid = 0; prev_ready = 0;
    for (int c = 0; c < 1500; c++) begin
      @(posedge clk); #1;
      cyc = c;
      start = (c == 0) || (restart && (c == 50 || done));
      case (mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = (c % 4 == 0) || (c % 4 == 3);
        default: bus.out_ready = 1'($urandom_range(0, 1));
      endcase
      bus.wre = (c >= wre_at) && (c < wre_at + wre_len);
      if (c == abort_at) begin
        rst = 1'b0;
        #1;
        check_zero("rst_mid");
        start = 1'b0; bus.wre = 1'b0; bus.out_ready = 1'b1;
        return;
      end
      @(negedge clk);
      if (c == 1) begin busy_c1 = busy; addr_c1 = bus.mem_read_addr; end
      if (c == 5) addr_c5 = bus.mem_read_addr;
      if (bus.wre && bus.mem_read_addr != 0) wre_bad++;
      if (prev_valid && !prev_ready &&
          !(bus.out_valid && bus.out_data == prev_data && bus.out_last == prev_last))
        stable_bad++;
      prev_valid = bus.out_valid; prev_ready = bus.out_ready;
      prev_data = bus.out_data; prev_last = bus.out_last;
      if (bus.out_valid && bus.out_ready) begin
        if (first_hs < 0) first_hs = c;
        got.push_back(bus.out_data);
        if (bus.out_last) begin last_idx = got.size() - 1; last_cnt++; end
      end
      if (done_cyc >= 0 && c > done_cyc && busy) post_busy++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) begin done_cyc = c; sum_done = sum_out; busy_done = busy; end
      end
      if (done_cyc >= 0 && c == done_cyc + 4) break;
    end
    start = 1'b0; bus.wre = 1'b0; bus.out_ready = 1'b1;
  endtask

  task automatic check_stream(input string tag);
    check({tag, "_count"}, got.size(), DEPTH);
    check({tag, "_order"}, order_errs(), 0);
    check({tag, "_last_idx"}, last_idx, DEPTH - 1);
    check({tag, "_last_cnt"}, last_cnt, 1);
    check({tag, "_done_cnt"}, done_cnt, 1);
    check({tag, "_sum"}, sum_done, exp_sum());
    check({tag, "_sum_held"}, sum_out, exp_sum());
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) ram[i] = 16'($urandom);
  endtask

  initial begin
    bus.out_ready = 1'b1;
    bus.wre = 1'b0;
    for (int i = 0; i < 256; i++) ram[i] = 16'(i - 120);
    #12;
    check_zero("reset");
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    // Ramp -120..119, full throughput.
    sweep(0, -100, 0, 1'b0, -1);
    check_stream("ramp");
    check("ramp_first_hs", first_hs, 3);
    check("ramp_done_cyc", done_cyc, 243);
    check("ramp_busy_c1", busy_c1, 1);
    check("ramp_addr_c1", addr_c1, 0);
    check("ramp_addr_c5", addr_c5, 4);
    check("ramp_busy_at_done", busy_done, 0);
    check("ramp_sum_value", sum_done, -120);

    // Ready pattern 1,0,0,1.
    fill_random();
    sweep(1, -100, 0, 1'b0, -1);
    check_stream("bp");
    check("bp_stable", stable_bad, 0);

    // wre high for 5 cycles mid-sweep.
    fill_random();
    sweep(0, 100, 5, 1'b0, -1);
    check_stream("wre");
    check("wre_no_issue", wre_bad, 0);
    check("wre_done_cyc", done_cyc, 248);

    // Start re-pulsed at cycle 50 and on done.
    fill_random();
    sweep(0, -100, 0, 1'b1, -1);
    check_stream("restart");
    check("restart_done_cyc", done_cyc, 243);
    check("restart_post_busy", post_busy, 0);

    // Reset mid-sweep, then a fresh sweep.
    fill_random();
    sweep(0, -100, 0, 1'b0, 100);
    repeat (2) @(posedge clk);
    #1 check_zero("rst_hold");
    rst = 1'b1;
    repeat (2) @(posedge clk);
    fill_random();
    sweep(0, -100, 0, 1'b0, -1);
    check_stream("after_rst");
    check("after_rst_addr_c1", addr_c1, 0);
    check("after_rst_done_cyc", done_cyc, 243);

    // Extremes.
    for (int i = 0; i < 256; i++) ram[i] = 16'h7FFF;
    sweep(0, -100, 0, 1'b0, -1);
    check_stream("max");
    check("max_sum_value", sum_done, 7864080);
    for (int i = 0; i < 256; i++) ram[i] = 16'h8000;
    sweep(0, -100, 0, 1'b0, -1);
    check_stream("min");
    check("min_sum_value", sum_done, -7864320);

    // Random data with random backpressure and a wre burst.
    fill_random();
    sweep(2, 60, 3, 1'b0, -1);
    check_stream("rand");
    check("rand_stable", stable_bad, 0);
    check("rand_no_issue", wre_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
